// File: rtl/rf_alu_sequencer.sv
// Read-execute-writeback sequencer for the register-file/ALU datapath.
// Each step k reads base+k and base+k+1 and writes the ALU result to base+k+2.
// Every output comes straight from a flop, so no input reaches an output combinationally.
module rf_alu_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  steps_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [ADDR_W-1:0] addr2_o,
  output logic [ADDR_W-1:0] addr3_o,
  output logic              write_enable_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  step_idx_o
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWrite, StFin} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q, addr3_q;
  logic              we_q, busy_q, done_q;
  // alu_op_q doubles as the latched opcode: it is only cleared when the run ends
  logic [OP_W-1:0]   alu_op_q;
  logic [CNT_W-1:0]  steps_q, idx_q;

  // Sequencer FSM with registered outputs; hold freezes every flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr1_q  <= '0;
      addr2_q  <= '0;
      addr3_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_op_q <= '0;
      steps_q  <= '0;
      idx_q    <= '0;
    end else if (!hold_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            steps_q <= steps_i;
            if (steps_i != '0) begin
              state_q  <= StRead;
              addr1_q  <= base_i;
              addr2_q  <= base_i + ADDR_W'(1);
              addr3_q  <= base_i + ADDR_W'(2);
              idx_q    <= '0;
              busy_q   <= 1'b1;
              alu_op_q <= op_i;
            end else begin
              // empty run: report completion without touching the addresses
              state_q <= StFin;
              done_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          state_q <= StExec;
        end
        StExec: begin
          state_q <= StWrite;
          we_q    <= 1'b1;
        end
        StWrite: begin
          we_q <= 1'b0;
          if (idx_q == steps_q - CNT_W'(1)) begin
            state_q  <= StFin;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            alu_op_q <= '0;
          end else begin
            state_q <= StRead;
            idx_q   <= idx_q + CNT_W'(1);
            addr1_q <= addr1_q + ADDR_W'(1);
            addr2_q <= addr2_q + ADDR_W'(1);
            addr3_q <= addr3_q + ADDR_W'(1);
          end
        end
        StFin: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign addr1_o        = addr1_q;
  assign addr2_o        = addr2_q;
  assign addr3_o        = addr3_q;
  assign write_enable_o = we_q;
  assign alu_op_o       = alu_op_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign step_idx_o     = idx_q;

endmodule
